// File: rtl/isa_sec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_sec_pkg
//  Description : Shared types and constants for the ISA sequencer: FSM
//                states, instruction field positions and datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_sec_pkg;

  localparam int INST_W   = 20;
  localparam int SALIDA_W = 32;

  // Instruction field layout: A[19:15] B[14:10] MODO[9] OP[8:6] DIR_RAM[5:1] WE[0]
  localparam int WE_BIT      = 0;
  localparam int DIR_RAM_LSB = 1;
  localparam int DIR_RAM_MSB = 5;
  localparam int OP_LSB      = 6;
  localparam int OP_MSB      = 8;
  localparam int MODO_BIT    = 9;
  localparam int B_LSB       = 10;
  localparam int B_MSB       = 14;
  localparam int A_LSB       = 15;
  localparam int A_MSB       = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EXEC  = 2'd2,
    CAPT  = 2'd3
  } sec_state_t;

  // Same instruction with the RAM write-enable bit cleared.
  function automatic logic [INST_W-1:0] we_off(input logic [INST_W-1:0] inst);
    logic [INST_W-1:0] r;
    r         = inst;
    r[WE_BIT] = 1'b0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/isa_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : isa_prog_mem
//  Description : Program store, DEPTH x INST_W, synchronous write and
//                combinational read. Contents are deliberately not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module isa_prog_mem
  import isa_sec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem [DEPTH];

  // Write port: one slot per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/isa_secuenciador.sv
`default_nettype none
// ============================================================================
//  Module      : isa_secuenciador
//  Description : Issues a stored program to the combinational ISA datapath
//                one instruction at a time. Each instruction is presented
//                with write-enable low for one settle cycle, with its stored
//                write-enable for HOLD cycles, then with write-enable low
//                again while the captured datapath output is reported.
//  Revision    : 1.0 - initial release
// ============================================================================
module isa_secuenciador
  import isa_sec_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int HOLD  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [INST_W-1:0]   prog_data,
  input  logic                start,
  input  logic [AW:0]         count,
  input  logic                abortar,
  output logic [INST_W-1:0]   instruccion,
  input  logic [SALIDA_W-1:0] salida_in,
  output logic [SALIDA_W-1:0] resultado,
  output logic                resultado_valido,
  output logic                ocupado,
  output logic                fin,
  output logic                error
);

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C     = (AW+1)'(1);
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD - 1);

  sec_state_t        state;
  logic [AW-1:0]     pc;
  logic [AW-1:0]     last_pc;
  logic [3:0]        hold_cnt;
  logic [INST_W-1:0] mem_rd;
  logic [INST_W-1:0] idle_inst;
  logic              mem_we;

  // Programming is only accepted while no run is in progress.
  assign mem_we = prog_we && (state == IDLE);

  isa_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (pc),
    .rd_data (mem_rd)
  );

  // Instruction mux: the stored write-enable reaches the datapath only in
  // EXEC, where state and pc are both stable, so field changes never race it.
  always_comb begin
    instruccion = idle_inst;
    case (state)
      SETUP:   instruccion = we_off(mem_rd);
      EXEC:    instruccion = mem_rd;
      CAPT:    instruccion = we_off(mem_rd);
      default: instruccion = idle_inst;
    endcase
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc               <= '0;
      last_pc          <= '0;
      hold_cnt         <= '0;
      idle_inst        <= '0;
      resultado        <= '0;
      resultado_valido <= 1'b0;
      ocupado          <= 1'b0;
      fin              <= 1'b0;
      error            <= 1'b0;
    end else begin
      resultado_valido <= 1'b0;
      fin              <= 1'b0;
      error            <= 1'b0;

      // Keep what IDLE shows after a run or abort: last fields, WE low.
      if (state != IDLE) begin
        idle_inst <= we_off(mem_rd);
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              fin <= 1'b1;
            end else if (count > DEPTH_C) begin
              error <= 1'b1;
            end else begin
              last_pc  <= AW'(count - ONE_C);
              pc       <= '0;
              hold_cnt <= '0;
              ocupado  <= 1'b1;
              state    <= SETUP;
            end
          end
        end

        SETUP: begin
          if (abortar) begin
            ocupado <= 1'b0;
            state   <= IDLE;
          end else begin
            hold_cnt <= '0;
            state    <= EXEC;
          end
        end

        EXEC: begin
          if (abortar) begin
            ocupado <= 1'b0;
            state   <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            resultado        <= salida_in;
            resultado_valido <= 1'b1;
            fin              <= (pc == last_pc);
            state            <= CAPT;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        CAPT: begin
          if (abortar || (pc == last_pc)) begin
            ocupado <= 1'b0;
            state   <= IDLE;
          end else begin
            pc    <= pc + AW'(1);
            state <= SETUP;
          end
        end

        default: begin
          ocupado <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isa_secuenciador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isa_secuenciador
//  Description : Directed self-checking bench for isa_secuenciador with a
//                small behavioural datapath (ALU on A/B values plus RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_isa_secuenciador;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [19:0] prog_data;
  logic        start;
  logic [4:0]  count;
  logic        abortar;
  logic [19:0] instruccion;
  logic [31:0] salida_in;
  logic [31:0] resultado;
  logic        resultado_valido;
  logic        ocupado;
  logic        fin;
  logic        error;

  int vectors;
  int miscompares;
  int we_edges;
  int w0;

  isa_secuenciador dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .prog_we          (prog_we),
    .prog_addr        (prog_addr),
    .prog_data        (prog_data),
    .start            (start),
    .count            (count),
    .abortar          (abortar),
    .instruccion      (instruccion),
    .salida_in        (salida_in),
    .resultado        (resultado),
    .resultado_valido (resultado_valido),
    .ocupado          (ocupado),
    .fin              (fin),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: A and B are 5-bit operand values, MODO=1 reads RAM.
  logic [31:0] ram_m [32];
  logic [31:0] a32, b32, alu_m;

  always_comb begin
    a32 = {27'd0, instruccion[19:15]};
    b32 = {27'd0, instruccion[14:10]};
    case (instruccion[8:6])
      3'b000:  alu_m = a32 & b32;
      3'b001:  alu_m = a32 | b32;
      3'b010:  alu_m = a32 + b32;
      3'b110:  alu_m = a32 - b32;
      3'b111:  alu_m = (a32 > b32) ? 32'd1 : 32'd0;
      default: alu_m = 32'd0;
    endcase
    salida_in = instruccion[9] ? ram_m[instruccion[5:1]] : alu_m;
  end

  // RAM writes on every edge that sees write-enable high.
  always @(posedge clk) begin
    if (instruccion[0] === 1'b1) begin
      ram_m[instruccion[5:1]] <= alu_m;
      we_edges <= we_edges + 1;
    end
  end

  function automatic logic [19:0] mk(input logic [4:0] a, input logic [4:0] b,
                                     input logic modo, input logic [2:0] op,
                                     input logic [4:0] dir, input logic we);
    return {a, b, modo, op, dir, we};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] addr, input logic [19:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    step();
    prog_we   = 1'b0;
  endtask

  logic [19:0] prog [6];
  logic [31:0] exp_res [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    we_edges    = 0;
    prog[0] = mk(5'd2,  5'd7,  1'b0, 3'b010, 5'd3, 1'b1);  // 2+7 -> RAM[3]
    prog[1] = mk(5'd0,  5'd0,  1'b1, 3'b000, 5'd3, 1'b0);  // read RAM[3]
    prog[2] = mk(5'd14, 5'd18, 1'b0, 3'b000, 5'd0, 1'b0);  // 14 & 18
    prog[3] = mk(5'd2,  5'd31, 1'b0, 3'b001, 5'd0, 1'b0);  // 2 | 31
    prog[4] = mk(5'd4,  5'd24, 1'b0, 3'b110, 5'd0, 1'b0);  // 4 - 24
    prog[5] = mk(5'd16, 5'd29, 1'b0, 3'b111, 5'd0, 1'b0);  // 16 > 29
    exp_res[0] = 32'd9;
    exp_res[1] = 32'd9;
    exp_res[2] = 32'd2;
    exp_res[3] = 32'd31;
    exp_res[4] = 32'hFFFF_FFEC;
    exp_res[5] = 32'd0;

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; count = '0; abortar = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst",  32'(instruccion), 32'd0);
    chk("rst_res",   resultado, 32'd0);
    chk("rst_valid", 32'(resultado_valido), 32'd0);
    chk("rst_ocup",  32'(ocupado), 32'd0);
    chk("rst_fin",   32'(fin), 32'd0);
    chk("rst_err",   32'(error), 32'd0);
    rst_n = 1'b1;
    step();

    // Single add instruction: WE gated, result in cycle 4
    load(4'd0, prog[0]);
    w0 = we_edges;
    start = 1'b1; count = 5'd1;
    step();
    start = 1'b0;
    chk("t1_setup_inst", 32'(instruccion), 32'(prog[0] & 20'hFFFFE));
    chk("t1_setup_ocup", 32'(ocupado), 32'd1);
    step();
    chk("t1_exec1_inst", 32'(instruccion), 32'(prog[0]));
    step();
    chk("t1_exec2_inst", 32'(instruccion), 32'(prog[0]));
    chk("t1_exec2_valid", 32'(resultado_valido), 32'd0);
    step();
    chk("t1_capt_res",   resultado, 32'd9);
    chk("t1_capt_valid", 32'(resultado_valido), 32'd1);
    chk("t1_capt_fin",   32'(fin), 32'd1);
    chk("t1_capt_we",    32'(instruccion[0]), 32'd0);
    step();
    chk("t1_idle_ocup",  32'(ocupado), 32'd0);
    chk("t1_idle_valid", 32'(resultado_valido), 32'd0);
    chk("t1_idle_inst",  32'(instruccion), 32'(prog[0] & 20'hFFFFE));
    chk("t1_we_edges",   32'(we_edges - w0), 32'd2);

    // Six datapath cases in one run
    for (int i = 0; i < 6; i++) load(4'(i), prog[i]);
    start = 1'b1; count = 5'd6;
    step();
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      chk($sformatf("t2_ocup_c%0d", k), 32'(ocupado), 32'd1);
      chk($sformatf("t2_valid_c%0d", k), 32'(resultado_valido), 32'((k % 4) == 0));
      chk($sformatf("t2_fin_c%0d", k), 32'(fin), 32'(k == 24));
      if ((k % 4) == 0) chk($sformatf("t2_res_%0d", k / 4), resultado, exp_res[k / 4 - 1]);
      if (k < 24) step();
    end
    step();
    chk("t2_end_ocup", 32'(ocupado), 32'd0);

    // count = 0 and count > DEPTH
    start = 1'b1; count = 5'd0;
    step();
    start = 1'b0;
    chk("t3_c0_fin",  32'(fin), 32'd1);
    chk("t3_c0_ocup", 32'(ocupado), 32'd0);
    chk("t3_c0_err",  32'(error), 32'd0);
    step();
    chk("t3_c0_fin_drop", 32'(fin), 32'd0);
    start = 1'b1; count = 5'd17;
    step();
    start = 1'b0;
    chk("t3_c17_err",  32'(error), 32'd1);
    chk("t3_c17_ocup", 32'(ocupado), 32'd0);
    chk("t3_c17_fin",  32'(fin), 32'd0);
    step();
    chk("t3_c17_err_drop", 32'(error), 32'd0);
    chk("t3_c17_ocup2",    32'(ocupado), 32'd0);

    // Abort during the second instruction's EXEC
    start = 1'b1; count = 5'd6;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("t4_first_res", resultado, 32'd9);
    step(); step();
    abortar = 1'b1;
    step();
    abortar = 1'b0;
    chk("t4_ocup",  32'(ocupado), 32'd0);
    chk("t4_res",   resultado, 32'd9);
    chk("t4_valid", 32'(resultado_valido), 32'd0);
    chk("t4_fin",   32'(fin), 32'd0);
    chk("t4_inst",  32'(instruccion), 32'(prog[1] & 20'hFFFFE));
    step();
    chk("t4_fin_later",  32'(fin), 32'd0);
    chk("t4_ocup_later", 32'(ocupado), 32'd0);

    // Asynchronous reset in EXEC, then rerun with the retained program
    start = 1'b1; count = 5'd1;
    step();
    start = 1'b0;
    step();
    chk("t5_exec_we", 32'(instruccion[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_inst", 32'(instruccion), 32'd0);
    chk("t5_rst_ocup", 32'(ocupado), 32'd0);
    chk("t5_rst_res",  resultado, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    start = 1'b1; count = 5'd1;
    step();
    start = 1'b0;
    chk("t5_rerun_setup", 32'(instruccion), 32'(prog[0] & 20'hFFFFE));
    step(); step(); step();
    chk("t5_rerun_res", resultado, 32'd9);
    chk("t5_rerun_fin", 32'(fin), 32'd1);
    step();

    // start and prog_we while busy are ignored
    start = 1'b1; count = 5'd2;
    step();
    start = 1'b1; count = 5'd1;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = prog[3];
    step();
    start = 1'b0; prog_we = 1'b0;
    chk("t6_ocup",  32'(ocupado), 32'd1);
    chk("t6_exec",  32'(instruccion), 32'(prog[0]));
    step(); step();
    chk("t6_res1",  resultado, 32'd9);
    chk("t6_fin1",  32'(fin), 32'd0);
    step(); step(); step(); step();
    chk("t6_valid2", 32'(resultado_valido), 32'd1);
    chk("t6_res2",   resultado, 32'd9);
    chk("t6_fin2",   32'(fin), 32'd1);
    step();
    chk("t6_end_ocup", 32'(ocupado), 32'd0);
    start = 1'b1; count = 5'd1;
    step();
    start = 1'b0;
    chk("t6_slot0_kept", 32'(instruccion), 32'(prog[0] & 20'hFFFFE));
    step(); step(); step();
    chk("t6_slot0_res", resultado, 32'd9);
    step();

    // Simultaneous prog_we and start in IDLE: run sees the new slot 0
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = prog[3];
    start = 1'b1; count = 5'd1;
    step();
    prog_we = 1'b0; start = 1'b0;
    chk("t7_setup_inst", 32'(instruccion), 32'(prog[3]));
    step(); step(); step();
    chk("t7_res", resultado, 32'd31);
    chk("t7_fin", 32'(fin), 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/isa_secuenciador.md
Name: isa_secuenciador

Overview:
- Sequencer for the combinational ISA datapath (register bank, ALU, RAM), which takes a 20-bit instruction and produces a 32-bit output.
- Holds a small loaded program and issues its instructions one at a time.
- Gates the RAM write-enable bit (inst[0]) so field transitions never cause spurious RAM writes.
- Captures the datapath output after a fixed settle time and reports per-instruction results.

Parameters:
- DEPTH, 16, number of program slots.
- AW, 4, program address width; DEPTH equals 2**AW.
- HOLD, 2, cycles the full instruction (write-enable live) is held before capture; legal range 1..15.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program slot to write.
- prog_data  in  20  instruction to store.
- start  in  1  single-cycle run request.
- count  in  AW+1  number of instructions to run, starting at slot 0.
- abortar  in  1  synchronous stop request.
- instruccion  out  20  instruction driven to the datapath.
- salida_in  in  32  datapath output (the datapath's Salida).
- resultado  out  32  captured output of the last completed instruction.
- resultado_valido  out  1  one-cycle pulse when resultado updates.
- ocupado  out  1  high while a run is in progress.
- fin  out  1  one-cycle pulse on the last instruction's capture.
- error  out  1  one-cycle pulse when start is given with an illegal count.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, hold counter=0.
  - instruccion, resultado, resultado_valido, ocupado, fin and error all 0.
  - Program memory contents are not reset.
- Programming:
  - When prog_we=1 in IDLE, mem[prog_addr] is written with prog_data at the clock edge.
  - prog_we is ignored while ocupado=1.
- Start, sampled in IDLE only:
  - count=0: fin pulses the next cycle; nothing is issued; ocupado stays 0.
  - count>DEPTH: error pulses the next cycle; the sequencer stays in IDLE.
  - Otherwise: latch count, pc=0, go to SETUP; ocupado=1 from the next cycle.
  - start is ignored while ocupado=1.
- SETUP (1 cycle): instruccion = {mem[pc][19:1], 1'b0}. Write-enable is forced low while the fields settle.
- EXEC (HOLD cycles): instruccion = mem[pc], with the stored write-enable bit.
- Capture edge: on the edge leaving the last EXEC cycle, resultado <= salida_in.
- CAPT (1 cycle):
  - instruccion has write-enable forced 0 again; resultado_valido=1.
  - If pc = count-1: fin=1 and the next state is IDLE, with ocupado=0 from the next cycle.
  - Otherwise pc increments and the next state is SETUP.
- Per-instruction latency is HOLD+2 cycles. A run of N instructions occupies N*(HOLD+2) cycles.
- In IDLE, instruccion holds the last value with bit0=0. After reset it is 0.
- abortar=1 in any busy state: next state is IDLE.
  - ocupado=0 and instruccion bit0=0 next cycle.
  - resultado is not updated; no resultado_valido or fin pulse.
  - abortar has priority over capture in the same cycle.
- Simultaneous prog_we and start in IDLE: the write takes effect, and the run starts reading the new contents, since mem is read at SETUP, one cycle later.
- pc wraps only within count; count=DEPTH runs slots 0..DEPTH-1.
- Async reset mid-run: immediate return to the reset values; instruccion bit0 drops to 0 asynchronously.

Decomposition:
- Package isa_sec_pkg:
  - State enum: IDLE, SETUP, EXEC, CAPT.
  - Instruction field constants: WE_BIT=0, DIR_RAM=[5:1], OP=[8:6], MODO=[9], B=[14:10], A=[19:15].
  - Width constant INST_W=20 and SALIDA_W=32.
- One sub-module, isa_prog_mem: DEPTH x 20 storage with a synchronous write and a combinational read addressed by pc.

Test Plan:
- Load slot0 = 00010_00111_0_010_00011_1 (2+7, write RAM[3]); count=1; start with the bench model driving salida_in=9.
  - instruccion bit0=0 in SETUP, =1 for 2 EXEC cycles, =0 in CAPT.
  - resultado=9 with resultado_valido and fin in cycle 4 after start.
- Load the six datapath cases (add, read, AND 14&18, OR 2|31, sub 4-24, gt 16>29); count=6; model outputs 9, 9, 2, 31, 0xFFFFFFEC, 0.
  - Six resultado_valido pulses, 4 cycles apart, in that order.
  - fin only with the 6th pulse; ocupado high for 24 cycles.
- count=0 -> fin pulse next cycle, ocupado=0. count=17 -> error pulse, no issue.
- Assert abortar in the 2nd instruction's EXEC -> ocupado=0 next cycle; resultado keeps the 1st value; no fin; bit0=0.
- Pull rst_n low mid-EXEC -> instruccion=0 and ocupado=0 immediately. start after release reruns from slot 0 with the retained program.
- Assert start and prog_we while ocupado=1 -> both ignored; the program and run sequence are unchanged.
